// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the sine-to-PWM modulator:
//   pwm_state_t  : dead-time generator states (SAFE, HI_ON, DEAD, LO_ON)
//   CARRIER_MAX  : last carrier count for an 8-bit sample width
//   DT_WIDTH     : width of the dead-time down-counter
//   carrier_max(): last carrier count for an arbitrary sample width
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        HI_ON = 2'd1,
        DEAD  = 2'd2,
        LO_ON = 2'd3
    } pwm_state_t;

    localparam int CARRIER_MAX = 254;
    localparam int DT_WIDTH    = 4;

    // The carrier stops one short of the all-ones sample so that a full-scale
    // sample keeps the compare true for the whole period (100 % duty).
    function automatic int carrier_max(input int width);
        if (width == 8) begin
            return CARRIER_MAX;
        end
        return (1 << width) - 2;
    endfunction

endpackage

// File: rtl/dead_time_gen.sv
// -----------------------------------------------------------------------------
// dead_time_gen
// Turns the raw compare bit into a complementary gate-drive pair with a
// guaranteed both-off interval of DEAD_CYCLES clocks on every side change.
// A raw level that does not persist for the whole dead time restarts the
// timer, so pulses shorter than the dead time never reach the outputs.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset (forces SAFE)
//   enable  in   run control; low forces SAFE on the next cycle
//   raw     in   unregistered carrier compare (1 = high side wanted)
//   pwm_hi  out  registered high-side gate drive
//   pwm_lo  out  registered low-side gate drive
// -----------------------------------------------------------------------------
module dead_time_gen
    import pwm_pkg::*;
#(
    parameter int DEAD_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam logic [DT_WIDTH-1:0] DT_LOAD = DT_WIDTH'(DEAD_CYCLES);

    pwm_state_t          state_q,  state_d;
    logic [DT_WIDTH-1:0] dt_q,     dt_d;
    logic                target_q, target_d;
    logic                pwm_hi_q, pwm_hi_d;
    logic                pwm_lo_q, pwm_lo_d;

    always_comb begin
        state_d  = state_q;
        dt_d     = dt_q;
        target_d = target_q;

        if (!enable) begin
            state_d = SAFE;
        end else begin
            case (state_q)
                SAFE: begin
                    state_d  = DEAD;
                    target_d = raw;
                    dt_d     = DT_LOAD;
                end
                HI_ON: begin
                    if (!raw) begin
                        state_d  = DEAD;
                        target_d = 1'b0;
                        dt_d     = DT_LOAD;
                    end
                end
                LO_ON: begin
                    if (raw) begin
                        state_d  = DEAD;
                        target_d = 1'b1;
                        dt_d     = DT_LOAD;
                    end
                end
                DEAD: begin
                    if (raw != target_q) begin
                        // Wanted side changed during the gap: start over.
                        target_d = raw;
                        dt_d     = DT_LOAD;
                    end else if (dt_q <= DT_WIDTH'(1)) begin
                        // dt counts DEAD_CYCLES..1 while in DEAD, so the gap
                        // is exactly DEAD_CYCLES clocks long.
                        state_d = target_q ? HI_ON : LO_ON;
                        dt_d    = '0;
                    end else begin
                        dt_d = dt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = SAFE;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so they
        // switch in the same cycle the state register does, glitch-free.
        pwm_hi_d = (state_d == HI_ON);
        pwm_lo_d = (state_d == LO_ON);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= SAFE;
            dt_q     <= '0;
            target_q <= 1'b0;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_q     <= dt_d;
            target_q <= target_d;
            pwm_hi_q <= pwm_hi_d;
            pwm_lo_q <= pwm_lo_d;
        end
    end

    assign pwm_hi = pwm_hi_q;
    assign pwm_lo = pwm_lo_q;

endmodule

// File: rtl/sine_pwm_modulator.sv
// -----------------------------------------------------------------------------
// sine_pwm_modulator
// Converts unsigned sine samples into a complementary, dead-time-protected PWM
// pair. Samples arrive over a valid/ready handshake into a one-deep shadow
// register; the shadow is promoted to the active duty only when the carrier
// wraps, so the compare value never changes in the middle of a period.
//
// Parameters:
//   SINE_SIZE    sample / carrier width (default 8)
//   DEAD_CYCLES  dead time in clocks, 1..15 (default 4)
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous active-high reset
//   enable        in   run control; low holds the carrier, outputs go safe
//   sample        in   unsigned duty sample (0 = 0 %, all ones = 100 %)
//   sample_valid  in   sample offered this cycle
//   sample_ready  out  shadow empty, sample can be accepted
//   pwm_hi        out  high-side gate drive
//   pwm_lo        out  low-side gate drive
//   period_start  out  one-cycle pulse in the cycle the carrier reads 0
//   duty          out  active compare value
// -----------------------------------------------------------------------------
module sine_pwm_modulator
    import pwm_pkg::*;
#(
    parameter int SINE_SIZE   = 8,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [SINE_SIZE-1:0] sample,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 pwm_hi,
    output logic                 pwm_lo,
    output logic                 period_start,
    output logic [SINE_SIZE-1:0] duty
);

    localparam logic [SINE_SIZE-1:0] CNT_LAST = SINE_SIZE'(carrier_max(SINE_SIZE));

    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 15) begin : g_bad_dead_cycles
        $error("sine_pwm_modulator: DEAD_CYCLES must be in 1..15");
    end

    logic [SINE_SIZE-1:0] cnt_q,          cnt_d;
    logic [SINE_SIZE-1:0] duty_q,         duty_d;
    logic [SINE_SIZE-1:0] shadow_q,       shadow_d;
    logic                 shadow_full_q,  shadow_full_d;
    logic                 period_start_q, period_start_d;

    logic wrap;
    logic accept;
    logic raw;

    assign wrap   = enable && (cnt_q == CNT_LAST);
    assign accept = sample_valid && !shadow_full_q;

    // cnt never reaches the all-ones value, so duty = all ones is always on
    // and duty = 0 is always off.
    assign raw = (cnt_q < duty_q);

    always_comb begin
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
        period_start_d = wrap;

        if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + SINE_SIZE'(1);
        end

        if (wrap && shadow_full_q) begin
            duty_d        = shadow_q;
            shadow_full_d = 1'b0;
        end

        // An accept can only happen with the shadow empty, so it never
        // collides with the promotion above; a sample accepted on the wrap
        // cycle waits for the following wrap.
        if (accept) begin
            shadow_d      = sample;
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            shadow_q       <= '0;
            shadow_full_q  <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            shadow_q       <= shadow_d;
            shadow_full_q  <= shadow_full_d;
            period_start_q <= period_start_d;
        end
    end

    dead_time_gen #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_dead_time_gen (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .raw    (raw),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

    assign sample_ready = !shadow_full_q;
    assign period_start = period_start_q;
    assign duty         = duty_q;

endmodule

// File: tb/tb_sine_pwm_modulator.sv
// -----------------------------------------------------------------------------
// tb_sine_pwm_modulator
// Directed bench for sine_pwm_modulator (SINE_SIZE = 8, DEAD_CYCLES = 4).
// Accepted samples are pushed to a scoreboard queue; a negedge monitor pops
// the next expected duty on every period_start and checks the active duty,
// output exclusivity and dead-time gaps every cycle. The main sequence walks
// through handshake latency, steady duty, back-pressure, boundary duties,
// disable and reset.
// -----------------------------------------------------------------------------
module tb_sine_pwm_modulator;

    localparam int SS   = 8;
    localparam int DEAD = 4;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [SS-1:0] sample;
    logic          sample_valid;
    logic          sample_ready;
    logic          pwm_hi;
    logic          pwm_lo;
    logic          period_start;
    logic [SS-1:0] duty;

    sine_pwm_modulator #(
        .SINE_SIZE   (SS),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty         (duty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [SS-1:0] sb[$];
    logic [SS-1:0] exp_duty  = '0;
    logic          rst_seen  = 1'b0;
    logic          mon_on    = 1'b0;
    int            low_run   = 0;
    int            last_side = 0;   // 0 none, 1 high side, 2 low side

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ps(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (period_start !== 1'b1 && n < budget);
        chk({tag, "_ps_seen"}, {31'd0, period_start}, 32'd1);
    endtask

    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 255; i++) begin
            hi += (pwm_hi === 1'b1) ? 1 : 0;
            lo += (pwm_lo === 1'b1) ? 1 : 0;
            tick();
        end
    endtask

    // Called in a period_start cycle with the shadow empty; returns at the
    // period_start that ends the measured (second) period.
    task automatic load_duty(input logic [SS-1:0] s, input string tag,
                             input int exp_hi, input int exp_lo);
        int n, hi, lo;
        chk({tag, "_ready"}, {31'd0, sample_ready}, 32'd1);
        sample       = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample       = SS'($urandom);
        wait_ps(tag, 300, n);
        chk({tag, "_duty"}, {24'd0, duty}, {24'd0, s});
        wait_ps({tag, "_skip"}, 300, n);
        measure(hi, lo);
        chk({tag, "_hi_count"}, hi, exp_hi);
        chk({tag, "_lo_count"}, lo, exp_lo);
        chk({tag, "_period"}, {31'd0, period_start}, 32'd1);
        $display("duty %02h: hi=%0d lo=%0d", s, hi, lo);
    endtask

    // Scoreboard / invariant monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (mon_on) begin
            if (rst_seen) begin
                sb.delete();
                exp_duty = '0;
            end
            if (period_start === 1'b1 && sb.size() > 0) begin
                exp_duty = sb.pop_front();
            end
            chk("duty_track", {24'd0, duty}, {24'd0, exp_duty});
            chk("no_overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
            if (pwm_hi === 1'b1) begin
                if (last_side == 2) chk("gap_lo_to_hi", {31'd0, low_run >= DEAD}, 32'd1);
                last_side = 1;
                low_run   = 0;
            end else if (pwm_lo === 1'b1) begin
                if (last_side == 1) chk("gap_hi_to_lo", {31'd0, low_run >= DEAD}, 32'd1);
                last_side = 2;
                low_run   = 0;
            end else begin
                low_run++;
            end
            rst_seen = (reset === 1'b1);
            if (!rst_seen && sample_valid === 1'b1 && sample_ready === 1'b1) begin
                sb.push_back(sample);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, hi, lo;

        reset        = 1'b1;
        enable       = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;

        // Reset state
        tick();
        mon_on = 1'b1;
        tick();
        chk("rst_ready",  {31'd0, sample_ready}, 32'd1);
        chk("rst_hi",     {31'd0, pwm_hi}, 32'd0);
        chk("rst_lo",     {31'd0, pwm_lo}, 32'd0);
        chk("rst_ps",     {31'd0, period_start}, 32'd0);
        chk("rst_duty",   {24'd0, duty}, 32'd0);
        $display("reset: ready=%0b hi=%0b lo=%0b duty=%02h", sample_ready, pwm_hi, pwm_lo, duty);

        // Handshake into an empty shadow
        reset        = 1'b0;
        enable       = 1'b1;
        sample       = 8'h80;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("hs_ready_fall", {31'd0, sample_ready}, 32'd0);
        wait_ps("hs", 400, n);
        chk("hs_ps_latency", n, 254);
        chk("hs_duty", {24'd0, duty}, 32'h80);
        chk("hs_ready_rise", {31'd0, sample_ready}, 32'd1);
        $display("handshake: 0x80 loaded after %0d cycles", n + 1);

        // Steady duty 0x80
        measure(hi, lo);
        chk("steady_hi", hi, 124);
        chk("steady_lo", lo, 123);
        chk("steady_period", {31'd0, period_start}, 32'd1);
        $display("steady 0x80: hi=%0d lo=%0d", hi, lo);

        // Back-pressure: 0x40 then 0xC0 back to back
        sample       = 8'h40;
        sample_valid = 1'b1;
        tick();
        chk("bp_ready_fall", {31'd0, sample_ready}, 32'd0);
        sample = 8'hC0;
        n = 0;
        do begin
            tick();
            n++;
        end while (sample_ready !== 1'b1 && n < 400);
        chk("bp_stall_len", n, 254);
        chk("bp_release_ps", {31'd0, period_start}, 32'd1);
        chk("bp_duty_40", {24'd0, duty}, 32'h40);
        tick();
        sample_valid = 1'b0;
        chk("bp_c0_taken", {31'd0, sample_ready}, 32'd0);
        wait_ps("bp", 300, n);
        chk("bp_duty_c0", {24'd0, duty}, 32'hC0);
        $display("back-pressure: stall=%0d duty=%02h", 254, duty);

        // Boundary duties
        load_duty(8'h00, "d00", 0, 255);
        load_duty(8'hFF, "dff", 255, 0);
        load_duty(8'h02, "d02", 0, 249);
        load_duty(8'h80, "d80", 124, 123);

        // Disable for 10 cycles at cnt = 100
        for (int i = 0; i < 100; i++) tick();
        chk("dis_before_hi", {31'd0, pwm_hi}, 32'd1);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dis_outputs", {30'd0, pwm_hi, pwm_lo}, 32'd0);
            chk("dis_no_ps", {31'd0, period_start}, 32'd0);
        end
        enable = 1'b1;
        for (int i = 0; i < DEAD; i++) begin
            tick();
            chk("reen_dead", {30'd0, pwm_hi, pwm_lo}, 32'd0);
        end
        tick();
        chk("reen_hi", {31'd0, pwm_hi}, 32'd1);
        wait_ps("reen", 300, n);
        chk("reen_cnt_held", n, 150);
        $display("disable: cnt held, period resumed after %0d more cycles", n + 5);

        // Reset mid-period with a pending shadow
        for (int i = 0; i < 10; i++) tick();
        sample       = 8'h33;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("rst2_pending", {31'd0, sample_ready}, 32'd0);
        for (int i = 0; i < 50; i++) tick();
        reset = 1'b1;
        tick();
        chk("rst2_outputs", {30'd0, pwm_hi, pwm_lo}, 32'd0);
        chk("rst2_ready", {31'd0, sample_ready}, 32'd1);
        chk("rst2_duty", {24'd0, duty}, 32'd0);
        chk("rst2_ps", {31'd0, period_start}, 32'd0);
        reset = 1'b0;
        wait_ps("rst2", 300, n);
        chk("rst2_period", n, 255);
        chk("rst2_shadow_dropped", {24'd0, duty}, 32'd0);
        $display("reset mid-period: duty=%02h after first wrap", duty);

        tick();
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_pwm_modulator.md
# sine_pwm_modulator

Converts the unsigned 8-bit sine samples from the sine generator into a complementary, dead-time-protected PWM pair for the output power stage. Sits directly downstream of the sine generator. A valid/ready handshake feeds a shadow register, and the shadow value is loaded into the active duty only at carrier wrap, so duty never changes mid-period.

## Interface
- `SINE_SIZE`, default 8: sample and carrier counter width.
- `DEAD_CYCLES`, default 4: dead-time length in clocks. Legal range is 1 to 15.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `enable`  in  1  run control. Low holds the carrier and forces the outputs safe.
- `sample`  in  SINE_SIZE  unsigned duty sample (0 = 0 %, 255 = 100 %).
- `sample_valid`  in  1  sample is offered this cycle.
- `sample_ready`  out  1  shadow register is empty, so a sample can be accepted.
- `pwm_hi`  out  1  high-side gate drive.
- `pwm_lo`  out  1  low-side gate drive.
- `period_start`  out  1  one-cycle pulse when the carrier wraps to 0.
- `duty`  out  SINE_SIZE  currently active compare value.

## Operation
- **Carrier.** `cnt` counts 0..254 and then wraps to 0, giving a period of 255 clocks. It increments only while `enable` = 1.
- **Raw compare.** `raw = (cnt < duty)`, unsigned, SINE_SIZE bits wide.
  - duty = 0 gives `raw` always 0.
  - duty = 255 gives `raw` always 1, because `cnt` never reaches 255.
- **Handshake.**
  - A sample is accepted on `sample_valid && sample_ready`. The sample is written to `shadow` and `shadow_full` is set.
  - `sample_ready = !shadow_full`.
  - `sample` may change freely while `sample_valid` = 0.
- **Wrap event.** A wrap is `enable` && `cnt` = 254. On a wrap:
  - `cnt` ← 0 and `period_start` ← 1 for one cycle.
  - If `shadow_full`: `duty` ← `shadow` and `shadow_full` ← 0.
  - If the shadow is empty, `duty` is unchanged.
- **Accept in the same cycle as a wrap.** This is only possible when the shadow was empty. The sample goes to `shadow` and reaches `duty` at the next wrap, not this one.
- **Dead-time FSM.** States are SAFE, HI_ON, DEAD, LO_ON. A 4-bit `dt` timer and a `target` bit support DEAD.
  - SAFE: both outputs 0. When `enable` = 1, go to DEAD with `target` = raw and `dt` = DEAD_CYCLES.
  - HI_ON: `pwm_hi` = 1. When raw = 0, go to DEAD with `target` = 0 and `dt` = DEAD_CYCLES.
  - LO_ON: `pwm_lo` = 1. When raw = 1, go to DEAD with `target` = 1 and `dt` = DEAD_CYCLES.
  - DEAD: both outputs 0.
    - If raw ≠ `target`, set `target` ← raw and reload `dt` (restart).
    - Otherwise decrement `dt`. When `dt` reaches 1, go to HI_ON if `target` = 1, else LO_ON.
  - Any state with `enable` = 0 goes to SAFE in the next cycle.
- **Invariants.**
  - `pwm_hi` && `pwm_lo` is never 1 at the same time.
  - Every transition between the two driven sides passes through at least DEAD_CYCLES cycles with both outputs low.
  - Pulses shorter than DEAD_CYCLES are swallowed.

## Timing
- **Reset values.**
  - `cnt` = 0, `duty` = 0, `shadow` = 0, `shadow_full` = 0, state = SAFE, `dt` = 0.
  - `sample_ready` = 1, `pwm_hi` = 0, `pwm_lo` = 0, `period_start` = 0.
- **Reset mid-period** aborts everything: the pending shadow is dropped and the outputs are low in the cycle after `reset` is sampled high.
- **Handshake latency.** `sample_ready` falls in the cycle after an accept. It rises in the cycle after the wrap that consumes the shadow.
- **Duty latency.** `duty` changes in the cycle after the wrap, which is the same cycle `cnt` = 0 and `period_start` = 1.
- **Output latency.** The outputs are registered FSM outputs, so `pwm_*` lags `raw` by 1 clock plus the dead time on every edge.
- **Disable.** Disable takes effect one cycle after `enable` falls. `cnt` holds its value; `duty` and `shadow` are retained.

## Structure
- A shared package `pwm_pkg` holds:
  - the `pwm_state_t` enum {SAFE, HI_ON, DEAD, LO_ON};
  - the constant `CARRIER_MAX` = 254;
  - the `DT_WIDTH` = 4 constant.
- The `SINE_SIZE` define is reused from the sine generator.
- One sub-module, `dead_time_gen`:
  - inputs: `clock`, `reset`, `enable`, `raw`;
  - outputs: `pwm_hi`, `pwm_lo`.
- The carrier, shadow and handshake logic stay in the top module.

## Test plan
- **Handshake into an empty shadow.** After reset, offer sample 0x80 with valid held high.
  - Accepted in the first cycle; `sample_ready` falls in the next cycle.
  - `duty` becomes 0x80 one cycle after the first wrap, i.e. at the cycle-255 `period_start`.
- **Steady duty 0x80 with DEAD_CYCLES = 4.**
  - `pwm_hi` high for 124 clocks per period and `pwm_lo` high for 123.
  - 4-clock low gaps on both edges; `pwm_hi` and `pwm_lo` never 1 together.
- **Boundary duties.**
  - duty 0x00: `pwm_lo` stays high permanently after the first period.
  - duty 0xFF: `pwm_hi` stays high permanently.
  - duty 0x02 (pulse shorter than the dead time): `pwm_hi` never rises.
- **Back-pressure.** Offer 0x40 then 0xC0 back-to-back with valid held high.
  - 0xC0 is stalled (`sample_ready` = 0) until the wrap.
  - `duty` sequence is 0x40 then 0xC0, one per period, with no sample lost.
- **Disable and reset mid-period.**
  - At `cnt` = 100, drop `enable` for 10 cycles: outputs go to 0 the next cycle and `cnt` holds at 100. On re-enable, the outputs stay low for 4 cycles before driving.
  - Asserting `reset` at any point gives all outputs 0, `sample_ready` = 1 and `duty` = 0 on the next cycle.
